// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: WIDTH-bit add/subtract sequenced through one 4-bit CLA slice, LSB nibble first.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p, c;
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s = p ^ c;
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, wres, wres_n;
  logic [CW-1:0] cnt;
  logic carry, co, last;
  logic [3:0] s;
  cla4 u_slice (
    .a (a_r[{cnt, 2'b00} +: 4]),
    .b (b_r[{cnt, 2'b00} +: 4]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  assign ready = state == IDLE;
  assign done = state == DONE;
  always_comb begin
    last = cnt == CW'(NIBBLES - 1);
    wres_n = wres;
    wres_n[{cnt, 2'b00} +: 4] = s;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      wres <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b ^ {WIDTH{sub}};
        carry <= sub | cin;
        cnt <= '0;
      end
      if (state == RUN) begin
        wres <= wres_n;
        carry <= co;
        cnt <= last ? cnt : cnt + 1'b1;
        if (last) begin
          sum <= wres_n;
          cout <= co;
          ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (wres_n[WIDTH-1] != a_r[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb_cla_serial_add_ctrl: directed vector table plus busy-rejection and mid-operation reset sequences.
module tb_cla_serial_add_ctrl;
  logic clk = 0, rst_n = 0, start = 0, cin = 0, sub = 0;
  logic [15:0] a = 0, b = 0, sum;
  logic ready, done, cout, ovf;
  int checks = 0, errors = 0;
  logic [15:0] prev_sum = 0;

  typedef struct {
    logic [15:0] a, b;
    logic cin, sub;
    logic [15:0] sum;
    logic cout, ovf;
  } vec_t;
  vec_t vt[10];

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int n;
    bit held;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1;
    @(negedge clk);
    start = 0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    n = 1;
    held = 1;
    while (!done && n < 20) begin
      if (sum !== prev_sum) held = 0;
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, n, 5);
    chk({name, " sum held"}, held, 1);
    chk({name, " sum"}, sum, v.sum);
    chk({name, " cout"}, cout, v.cout);
    chk({name, " ovf"}, ovf, v.ovf);
    chk({name, " ready in done"}, ready, 0);
    @(negedge clk);
    chk({name, " ready after"}, ready, 1);
    chk({name, " done cleared"}, done, 0);
    prev_sum = v.sum;
  endtask

  initial begin
    int dones, at;
    vt[0] = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0};
    vt[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    vt[2] = '{16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0};
    vt[3] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0};
    vt[4] = '{16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0};
    vt[5] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    vt[6] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1};
    vt[7] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 1, 0};
    vt[8] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    vt[9] = '{16'hABCD, 16'h1234, 1, 0, 16'hBE02, 0, 0};

    #12;
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) run_op(vt[i], $sformatf("vec%0d", i));

    // busy rejection: start pulses in cycle 2 (RUN) and cycle 5 (DONE) must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; start = 1;
    dones = 0;
    at = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin dones++; at = k; end
      start = (k == 2 || k == 5);
      a = k[0] ? 16'hAAAA : 16'h5A5A;
      b = k[0] ? 16'h5555 : 16'hA5A5;
    end
    chk("busy done count", dones, 1);
    chk("busy done cycle", at, 5);
    chk("busy sum", sum, 16'h3333);
    chk("busy cout", cout, 0);
    chk("busy ovf", ovf, 0);
    chk("busy ready", ready, 1);

    // reset in cycle 3 between edges discards the op
    a = 16'h1234; b = 16'h4321; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst ready", ready, 1);
    chk("midrst done", done, 0);
    @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst no done", dones, 0);
    prev_sum = 0;
    run_op('{16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0}, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
